// File: rtl/barrido_teclado_pkg.sv
// -----------------------------------------------------------------------------
// teclado_pkg
// Shared types and constants for the 4x4 keypad scanner (barrido_teclado).
//   estado_t    : debounce FSM states
//   COL_INICIAL : column driven first after reset (bit 3 = first column)
//   COL_FINAL   : last column of a scan; its dwell wrap is the scan boundary
//   NINGUNA     : "no key" row/column value
//   es_onehot() : true when exactly one bit of a 4-bit vector is set
// -----------------------------------------------------------------------------
package teclado_pkg;

    typedef enum logic [1:0] {
        LIBRE         = 2'd0,
        REBOTE_PULSA  = 2'd1,
        SOSTENIDA     = 2'd2,
        REBOTE_SUELTA = 2'd3
    } estado_t;

    localparam logic [3:0] COL_INICIAL = 4'b1000;
    localparam logic [3:0] COL_FINAL   = 4'b0001;
    localparam logic [3:0] NINGUNA     = 4'b0000;

    function automatic logic es_onehot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/barrido_teclado_if.sv
// -----------------------------------------------------------------------------
// barrido_teclado_if
// Keypad-side and comparator-side signals of the scanner.
//   fil_in       : raw keypad rows, active-high, asynchronous (bit 3 = row 0)
//   col_out      : one-hot column drive to the keypad
//   fil, col     : latched one-hot row/column of the accepted key
//   tecla_valida : one-cycle pulse when a new press is accepted
//   presionada   : high while the accepted key is held
//   estado       : debounce FSM state, for observation only
// Modports: master = the scanner, slave = keypad/comparator/observer side.
// Handshake: tecla_valida is a single-cycle valid with no ready; fil/col are
// stable from that cycle until the next accepted key or a reset.
// -----------------------------------------------------------------------------
interface barrido_teclado_if;
    import teclado_pkg::*;

    logic [3:0] fil_in;
    logic [3:0] col_out;
    logic [3:0] fil;
    logic [3:0] col;
    logic       tecla_valida;
    logic       presionada;
    estado_t    estado;

    modport master (
        input  fil_in,
        output col_out, fil, col, tecla_valida, presionada, estado
    );

    modport slave (
        output fil_in,
        input  col_out, fil, col, tecla_valida, presionada, estado
    );

endinterface

// File: rtl/barrido_teclado_sincronizador.sv
// -----------------------------------------------------------------------------
// sincronizador
// Two-flop synchronizer for a W-bit bus of independent asynchronous levels.
//   clk, rst_n : system clock, asynchronous active-low reset (clears to 0)
//   d_i        : asynchronous input
//   q_o        : input re-timed to clk, two cycles of latency
// -----------------------------------------------------------------------------
module sincronizador #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/barrido_teclado.sv
// -----------------------------------------------------------------------------
// barrido_teclado
// 4x4 keypad scanner and debouncer. Drives the columns one-hot in rotation,
// samples the synchronized rows at the end of each column dwell, reduces each
// full scan to NONE / KEY(f,c) / INVALID and debounces presses and releases
// over DEBOUNCE_SCANS identical scans.
//   SCAN_DIV       : cycles each column is driven (>= 4)
//   DEBOUNCE_SCANS : identical scans needed to accept a press/release (1..15)
//   clk, rst_n     : system clock, asynchronous active-low reset
//   bus            : barrido_teclado_if.master (rows in; columns, key, status out)
// -----------------------------------------------------------------------------
module barrido_teclado
    import teclado_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    barrido_teclado_if.master  bus
);

    localparam int             CW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [3:0]     DEB_ULT = 4'(DEBOUNCE_SCANS - 1);

    logic [3:0]    fil_s;

    // Dwell counter, column drive and per-scan accumulator.
    logic [CW-1:0] dwell_q,   dwell_d;
    logic [3:0]    col_act_q, col_act_d;
    logic          acc_hit_q, acc_hit_d;
    logic          acc_inv_q, acc_inv_d;
    logic [3:0]    acc_fil_q, acc_fil_d;
    logic [3:0]    acc_col_q, acc_col_d;

    // Debounce FSM and registered outputs.
    estado_t       estado_q;
    logic [3:0]    cand_fil_q, cand_col_q;
    logic [3:0]    cont_q;
    logic [3:0]    fil_q, col_q;
    logic          tecla_valida_q;
    logic          presionada_q;

    logic          fin_dwell, fin_barrido;
    logic          muestra_nz;
    logic          res_hit, res_inv, res_tecla;
    logic [3:0]    res_fil, res_col;
    logic          igual_cand, igual_lat;

    sincronizador #(.W(4)) u_sinc (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (bus.fil_in),
        .q_o   (fil_s)
    );

    assign fin_dwell   = (dwell_q == CNT_MAX);
    assign fin_barrido = fin_dwell && (col_act_q == COL_FINAL);

    // Scan result including the sample taken this cycle, so the last column
    // is part of the result evaluated at the scan boundary.
    assign muestra_nz = |fil_s;
    assign res_hit    = acc_hit_q | muestra_nz;
    assign res_inv    = acc_inv_q | (muestra_nz & (acc_hit_q | !es_onehot(fil_s)));
    assign res_fil    = (muestra_nz && !acc_hit_q) ? fil_s     : acc_fil_q;
    assign res_col    = (muestra_nz && !acc_hit_q) ? col_act_q : acc_col_q;
    // INVALID collapses into NONE: only a clean single key counts.
    assign res_tecla  = res_hit & !res_inv;

    assign igual_cand = (res_fil == cand_fil_q) && (res_col == cand_col_q);
    assign igual_lat  = (res_fil == fil_q) && (res_col == col_q);

    always_comb begin
        dwell_d   = dwell_q + CW'(1);
        col_act_d = col_act_q;
        acc_hit_d = acc_hit_q;
        acc_inv_d = acc_inv_q;
        acc_fil_d = acc_fil_q;
        acc_col_d = acc_col_q;
        if (fin_dwell) begin
            dwell_d   = '0;
            col_act_d = {col_act_q[0], col_act_q[3:1]};
            if (fin_barrido) begin
                acc_hit_d = 1'b0;
                acc_inv_d = 1'b0;
                acc_fil_d = NINGUNA;
                acc_col_d = NINGUNA;
            end else begin
                acc_hit_d = res_hit;
                acc_inv_d = res_inv;
                acc_fil_d = res_fil;
                acc_col_d = res_col;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_q   <= '0;
            col_act_q <= COL_INICIAL;
            acc_hit_q <= 1'b0;
            acc_inv_q <= 1'b0;
            acc_fil_q <= NINGUNA;
            acc_col_q <= NINGUNA;
        end else begin
            dwell_q   <= dwell_d;
            col_act_q <= col_act_d;
            acc_hit_q <= acc_hit_d;
            acc_inv_q <= acc_inv_d;
            acc_fil_q <= acc_fil_d;
            acc_col_q <= acc_col_d;
        end
    end

    // Debounce FSM: acts only at scan boundaries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q       <= LIBRE;
            cand_fil_q     <= NINGUNA;
            cand_col_q     <= NINGUNA;
            cont_q         <= 4'd0;
            fil_q          <= NINGUNA;
            col_q          <= NINGUNA;
            tecla_valida_q <= 1'b0;
            presionada_q   <= 1'b0;
        end else begin
            tecla_valida_q <= 1'b0;
            if (fin_barrido) begin
                case (estado_q)
                    LIBRE: begin
                        if (res_tecla) begin
                            cand_fil_q <= res_fil;
                            cand_col_q <= res_col;
                            if (DEBOUNCE_SCANS == 1) begin
                                fil_q          <= res_fil;
                                col_q          <= res_col;
                                tecla_valida_q <= 1'b1;
                                presionada_q   <= 1'b1;
                                cont_q         <= 4'd0;
                                estado_q       <= SOSTENIDA;
                            end else begin
                                cont_q   <= 4'd1;
                                estado_q <= REBOTE_PULSA;
                            end
                        end
                    end
                    REBOTE_PULSA: begin
                        if (res_tecla && igual_cand) begin
                            if (cont_q >= DEB_ULT) begin
                                fil_q          <= cand_fil_q;
                                col_q          <= cand_col_q;
                                tecla_valida_q <= 1'b1;
                                presionada_q   <= 1'b1;
                                cont_q         <= 4'd0;
                                estado_q       <= SOSTENIDA;
                            end else begin
                                cont_q <= cont_q + 4'd1;
                            end
                        end else if (res_tecla) begin
                            cand_fil_q <= res_fil;
                            cand_col_q <= res_col;
                            cont_q     <= 4'd1;
                        end else begin
                            cont_q   <= 4'd0;
                            estado_q <= LIBRE;
                        end
                    end
                    SOSTENIDA: begin
                        if (!(res_tecla && igual_lat)) begin
                            cont_q   <= 4'd1;
                            estado_q <= REBOTE_SUELTA;
                        end
                    end
                    REBOTE_SUELTA: begin
                        if (!res_tecla) begin
                            // Count may already exceed DEB_ULT when DEBOUNCE_SCANS=1.
                            if (cont_q >= DEB_ULT) begin
                                presionada_q <= 1'b0;
                                cont_q       <= 4'd0;
                                estado_q     <= LIBRE;
                            end else begin
                                cont_q <= cont_q + 4'd1;
                            end
                        end else if (igual_lat) begin
                            cont_q   <= 4'd0;
                            estado_q <= SOSTENIDA;
                        end else begin
                            // A different key holds off the release.
                            cont_q <= 4'd0;
                        end
                    end
                    default: begin
                        cont_q   <= 4'd0;
                        estado_q <= LIBRE;
                    end
                endcase
            end
        end
    end

    assign bus.col_out      = col_act_q;
    assign bus.fil          = fil_q;
    assign bus.col          = col_q;
    assign bus.tecla_valida = tecla_valida_q;
    assign bus.presionada   = presionada_q;
    assign bus.estado       = estado_q;

endmodule

// File: tb/tb_barrido_teclado.sv
// -----------------------------------------------------------------------------
// tb_barrido_teclado
// Bench for barrido_teclado with SCAN_DIV=4, DEBOUNCE_SCANS=3 (16-cycle scan).
// A keypad model turns up to two pressed keys plus col_out into fil_in.
// Expected pulses {fil, col, cycle} are queued by the stimulus; a monitor
// pops and compares on every tecla_valida.
// Presses are applied right at a scan start, so a key is accepted exactly
// 48 cycles (3 scans) later, and a release clears presionada 48 cycles later.
// -----------------------------------------------------------------------------
module tb_barrido_teclado;
    import teclado_pkg::*;

    localparam int W = 40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cyc = 32'd0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] e_mon;
    int tests = 0;
    int fails = 0;

    // Keypad model state.
    logic       k0_en = 1'b0, k1_en = 1'b0;
    logic [3:0] k0_f = 4'b0000, k0_c = 4'b0000;
    logic [3:0] k1_f = 4'b0000, k1_c = 4'b0000;
    logic [3:0] kb_rows;

    barrido_teclado_if ifc ();

    barrido_teclado #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.master)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    always_comb begin
        kb_rows = 4'b0000;
        if (k0_en && ((ifc.col_out & k0_c) != 4'b0000)) kb_rows = kb_rows | k0_f;
        if (k1_en && ((ifc.col_out & k1_c) != 4'b0000)) kb_rows = kb_rows | k1_f;
    end
    assign ifc.fil_in = kb_rows;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Returns on the negedge right after col_out wraps 0001 -> 1000.
    task automatic wait_scan_start();
        logic [3:0] prev;
        prev = ifc.col_out;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (prev == 4'b0001 && ifc.col_out == 4'b1000) return;
            prev = ifc.col_out;
        end
        check("scan_start_timeout", 32'd1, 32'd0);
    endtask

    task automatic expect_pulse(input logic [3:0] f, input logic [3:0] c, input int dly);
        exp_q.push_back({f, c, cyc + 32'(dly)});
    endtask

    task automatic check_no_pending(input string name);
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ifc.tecla_valida === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                e_mon = exp_q.pop_front();
                check("pulse_fil",   32'(ifc.fil), 32'(e_mon[39:36]));
                check("pulse_col",   32'(ifc.col), 32'(e_mon[35:32]));
                check("pulse_cycle", cyc,          e_mon[31:0]);
                check("pulse_pres",  32'(ifc.presionada), 32'd1);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;

        // Reset behaviour and free-running column rotation.
        wait_neg(3);
        check("rst_col_out", 32'(ifc.col_out), 32'h8);
        check("rst_fil",     32'(ifc.fil), 32'h0);
        check("rst_col",     32'(ifc.col), 32'h0);
        check("rst_tv",      32'(ifc.tecla_valida), 32'h0);
        check("rst_pres",    32'(ifc.presionada), 32'h0);
        check("rst_estado",  32'(ifc.estado), 32'(LIBRE));
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check("rotation", 32'(ifc.col_out), 32'(4'b1000 >> ((k / 4) % 4)));
        end
        check("idle_tv",  32'(ifc.tecla_valida), 32'h0);
        check("idle_fil", 32'(ifc.fil), 32'h0);

        // Clean press of key row 0100 / column 0010.
        wait_scan_start();
        expect_pulse(4'b0100, 4'b0010, 48);
        k0_f = 4'b0100; k0_c = 4'b0010; k0_en = 1'b1;
        wait_neg(47);
        check("press_pres_before", 32'(ifc.presionada), 32'd0);
        wait_neg(1);
        check("press_pres_at", 32'(ifc.presionada), 32'd1);
        wait_neg(48);
        check("press_hold_pres", 32'(ifc.presionada), 32'd1);
        check("press_hold_estado", 32'(ifc.estado), 32'(SOSTENIDA));
        check_no_pending("press_pending");
        // Release.
        wait_scan_start();
        k0_en = 1'b0;
        wait_neg(47);
        check("rel_pres_before", 32'(ifc.presionada), 32'd1);
        wait_neg(1);
        check("rel_pres_after", 32'(ifc.presionada), 32'd0);
        check("rel_estado",     32'(ifc.estado), 32'(LIBRE));
        check("rel_fil_kept",   32'(ifc.fil), 32'h4);
        check("rel_col_kept",   32'(ifc.col), 32'h2);

        // Bounce on press: key row 0001 / column 0100 on/off for two scans each.
        k0_f = 4'b0001; k0_c = 4'b0100;
        for (int t = 0; t < 4; t++) begin
            wait_scan_start();
            k0_en = (t % 2 == 0);
        end
        wait_scan_start();
        check("bounce_estado", 32'(ifc.estado), 32'(LIBRE));
        expect_pulse(4'b0001, 4'b0100, 48);
        k0_en = 1'b1;
        wait_neg(48);
        check("bounce_pres", 32'(ifc.presionada), 32'd1);
        wait_scan_start();
        k0_en = 1'b0;
        wait_neg(48);
        check("bounce_rel_pres", 32'(ifc.presionada), 32'd0);
        check_no_pending("bounce_pending");

        // Two keys in different columns, then release one.
        wait_scan_start();
        k0_f = 4'b1000; k0_c = 4'b1000; k0_en = 1'b1;
        k1_f = 4'b0100; k1_c = 4'b0001; k1_en = 1'b1;
        wait_neg(80);
        check("two_keys_pres",   32'(ifc.presionada), 32'd0);
        check("two_keys_estado", 32'(ifc.estado), 32'(LIBRE));
        wait_scan_start();
        expect_pulse(4'b0100, 4'b0001, 48);
        k0_en = 1'b0;
        wait_neg(48);
        check("two_keys_accept_pres", 32'(ifc.presionada), 32'd1);
        wait_scan_start();
        k1_en = 1'b0;
        wait_neg(48);
        check("two_keys_rel_pres", 32'(ifc.presionada), 32'd0);
        check_no_pending("two_keys_pending");

        // Bounce on release.
        wait_scan_start();
        expect_pulse(4'b0100, 4'b0010, 48);
        k0_f = 4'b0100; k0_c = 4'b0010; k0_en = 1'b1;
        wait_neg(48);
        check("rb_pres_accept", 32'(ifc.presionada), 32'd1);
        wait_scan_start();
        k0_en = 1'b0;
        wait_scan_start();
        check("rb_estado_suelta", 32'(ifc.estado), 32'(REBOTE_SUELTA));
        check("rb_pres_drop",     32'(ifc.presionada), 32'd1);
        k0_en = 1'b1;
        wait_neg(16);
        check("rb_estado_back", 32'(ifc.estado), 32'(SOSTENIDA));
        for (int i = 0; i < 12; i++) begin
            wait_neg(4);
            check("rb_pres_held", 32'(ifc.presionada), 32'd1);
        end
        wait_scan_start();
        k0_en = 1'b0;
        wait_neg(47);
        check("rb_true_rel_before", 32'(ifc.presionada), 32'd1);
        wait_neg(1);
        check("rb_true_rel_after", 32'(ifc.presionada), 32'd0);
        check_no_pending("rb_pending");

        // Reset in the middle of a press debounce.
        wait_scan_start();
        k0_f = 4'b0001; k0_c = 4'b1000; k0_en = 1'b1;
        wait_neg(21);
        check("mid_estado_pulsa", 32'(ifc.estado), 32'(REBOTE_PULSA));
        check("mid_col_out_pre",  32'(ifc.col_out), 32'h4);
        rst_n = 1'b0;
        #1;
        check("mid_rst_col_out", 32'(ifc.col_out), 32'h8);
        check("mid_rst_fil",     32'(ifc.fil), 32'h0);
        check("mid_rst_col",     32'(ifc.col), 32'h0);
        check("mid_rst_tv",      32'(ifc.tecla_valida), 32'h0);
        check("mid_rst_pres",    32'(ifc.presionada), 32'h0);
        check("mid_rst_estado",  32'(ifc.estado), 32'(LIBRE));
        wait_neg(3);
        rst_n = 1'b1;
        expect_pulse(4'b0001, 4'b1000, 48);
        wait_neg(47);
        check("mid_pres_before", 32'(ifc.presionada), 32'd0);
        wait_neg(1);
        check("mid_pres_after", 32'(ifc.presionada), 32'd1);
        wait_neg(20);
        check_no_pending("mid_pending");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/barrido_teclado.md
# barrido_teclado

Scanner and debouncer for the 4x4 matrix keypad, sitting directly upstream of `Comparador_col`. It drives the keypad columns one-hot in rotation and samples the raw row lines. It debounces a single pressed key over whole scans, then presents the stable one-hot `fil`/`col` pair and a one-cycle `tecla_valida` pulse. The comparator turns that pair into the 4-bit key code.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each column is driven (dwell); legal range is 4 or more.
- `DEBOUNCE_SCANS`, default 4: number of consecutive identical full scans needed to accept a press or a release; legal range is 1 to 15.
- `clk` input, 1 bit: single system clock; every flop is in this domain.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `fil_in` input, 4 bits: raw keypad rows, active-high, asynchronous to `clk`; bit 3 is the first row.
- `col_out` output, 4 bits: one-hot column drive to the keypad; bit 3 is the first column.
- `fil` output, 4 bits: latched one-hot row of the accepted key, fed to `Comparador_col.fil`.
- `col` output, 4 bits: latched one-hot column of the accepted key, fed to `Comparador_col.col`.
- `tecla_valida` output, 1 bit: one-cycle pulse when a new press is accepted.
- `presionada` output, 1 bit: high while the accepted key is held, including during release debounce.

## Operation
- Reset values: `col_out`=4'b1000, `fil`=4'b0000, `col`=4'b0000, `tecla_valida`=0, `presionada`=0, FSM=`LIBRE`, all counters=0.
- `fil_in` passes through a 2-flop synchronizer before any use.
- Column rotation: 1000 → 0100 → 0010 → 0001 → 1000. A dwell counter counts 0 to SCAN_DIV-1 and advances the column when it wraps. The counter runs freely in every FSM state.
- Row sampling: the synchronized rows are sampled in the last cycle of each dwell (count = SCAN_DIV-1).
- Per-scan result, built across the four columns:
  - NONE: all samples are zero.
  - KEY(f,c): exactly one sample is nonzero and it is one-hot.
  - INVALID: anything else (multiple rows in one column, or keys in two or more columns). INVALID is treated as NONE.
- Scan boundary: the dwell wrap of column 0001. The result is evaluated here and the accumulator is cleared.
- FSM states and transitions:
  - `LIBRE`: on KEY(f,c), store the candidate, set stable count to 1, go to `REBOTE_PULSA`. When DEBOUNCE_SCANS=1, go directly to `SOSTENIDA` with the pulse.
  - `REBOTE_PULSA`: a result equal to the candidate increments the count. At count = DEBOUNCE_SCANS, latch `fil`/`col`, pulse `tecla_valida`, go to `SOSTENIDA`. A different KEY restarts with the new candidate at count 1. NONE returns to `LIBRE`.
  - `SOSTENIDA`: a result equal to the latched key stays. Any other result sets release count to 1 and goes to `REBOTE_SUELTA`.
  - `REBOTE_SUELTA`: NONE increments the release count. At DEBOUNCE_SCANS, go to `LIBRE` and clear `presionada`; `fil`/`col` keep their last value. The latched key returns to `SOSTENIDA` with no new pulse. A different key resets the release count to 0 and stays in this state.
- A second key can only be accepted after a full release.
- Reset asserted mid-scan or mid-debounce returns everything to the reset values immediately.

## Timing
- Scan period is 4·SCAN_DIV cycles. Input-to-sample delay is 2 cycles (synchronizer); SCAN_DIV ≥ 4 guarantees settling after a column switch.
- `tecla_valida` is high for exactly the one cycle after the accepting scan boundary.
- `presionada` rises in that same cycle.
- `fil`/`col` change only in that same cycle.
- Press latency, from a clean steady press to the pulse: between DEBOUNCE_SCANS and DEBOUNCE_SCANS+1 scan periods, plus 1 cycle.
- Release latency: DEBOUNCE_SCANS to DEBOUNCE_SCANS+1 scans.
- All outputs are registered.

## Structure
- Package `teclado_pkg` holds:
  - the state enum {`LIBRE`, `REBOTE_PULSA`, `SOSTENIDA`, `REBOTE_SUELTA`};
  - `COL_INICIAL` = 4'b1000;
  - `NINGUNA` = 4'b0000.
- Natural sub-module: `sincronizador`, a 2-flop, 4-bit synchronizer with the same clock and reset.
- Everything else lives in one module.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=3, giving a 16-cycle scan.
- Reset behaviour: release reset, no keys → `col_out` cycles 1000/0100/0010/0001 every 4 cycles; `tecla_valida` stays 0 and `fil`=`col`=0000.
- Clean press: model the key at row 0100 / column 0010 (key 3) → one `tecla_valida` pulse with `fil`=0100, `col`=0010 after 3–4 scans; `presionada` stays high while held; no further pulses.
- Bounce on press: toggle the key for 2 scans, then hold it → no pulse during the bounce; exactly one pulse 3 scans after it becomes steady.
- Two keys in different columns: press (1000,1000) and (0100,0001) together → no pulse; release one → the other is accepted normally.
- Bounce on release: hold the key, drop it for 1 scan, restore it → no second pulse and `presionada` stays 1. A true release lasting 3 scans clears `presionada`.
- Mid-debounce reset: assert `rst_n`=0 while in `REBOTE_PULSA` → all outputs return to their reset values within the same cycle; a subsequent press needs a full 3-scan debounce again.
